// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with an 8-deep byte FIFO and a pollable status word.
// Latency: a write into an empty idle block pops one edge later, and tx falls after the second edge.
// Backpressure: writes while the FIFO is full are dropped and set a sticky overflow flag; status reads are side-effect free.
module uart_tx_io #(
    parameter int CLKS_PER_BIT = 2396,
    parameter int FIFO_AW      = 3
) (
    input  logic        uartclk,
    input  logic        uartrst,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [7:0]  uartwdata,
    output logic [15:0] uartrdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int                 BC_W      = $clog2(CLKS_PER_BIT);
    localparam logic [BC_W-1:0]    L_BC_LAST = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   L_DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BC_W-1:0]      r_bc;
    logic [BC_W-1:0]      w_bc_nxt;
    logic [2:0]           r_bi;
    logic [2:0]           w_bi_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_nxt;
    logic                 w_tx_nxt;
    logic                 w_pop;

    logic [7:0]           r_mem [0:(1<<FIFO_AW)-1];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_ovf;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_wr_sel;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_ovf_clr;
    logic                 w_full;
    logic                 w_empty;
    logic [7:0]           w_head;
    logic [3:0]           w_cnt4;
    logic [15:0]          w_status;

    // Bus decode; full/empty come from the pre-edge count so push acceptance ignores a same-cycle pop.
    assign w_wr_sel   = uartcs & uartwrite;
    assign w_push_req = w_wr_sel & (uartaddr == 2'b00);
    assign w_full     = (r_count == L_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_push     = w_push_req & ~w_full;
    assign w_ovf_clr  = w_wr_sel & (uartaddr == 2'b10);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_cnt4     = 4'(r_count);
    assign w_status   = {8'h00, w_cnt4, r_ovf, w_full, w_empty, r_busy};
    assign uartrdata  = (uartcs & uartread & (uartaddr == 2'b00)) ? w_status : 16'h0000;
    assign tx         = r_tx;
    assign tx_busy    = r_busy;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge uartclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= uartwdata;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge uartclk) begin
        if (uartrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req & w_full) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serialiser state, counters and the registered line/busy outputs.
    always_ff @(posedge uartclk) begin
        if (uartrst) begin
            r_state <= S_IDLE;
            r_bc    <= '0;
            r_bi    <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bc    <= w_bc_nxt;
            r_bi    <= w_bi_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (r_state != S_IDLE) | ~w_empty;
        end
    end

    // Next-state logic; the stop bit's last cycle pops straight into a new start bit when data waits.
    always_comb begin
        w_state_nxt = r_state;
        w_bc_nxt    = r_bc;
        w_bi_nxt    = r_bi;
        w_shift_nxt = r_shift;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_bc_nxt    = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (r_bc == L_BC_LAST) begin
                    w_bc_nxt    = '0;
                    w_bi_nxt    = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_bc_nxt = r_bc + 1'b1;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (r_bc == L_BC_LAST) begin
                    w_bc_nxt    = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bi == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bi_nxt = r_bi + 3'd1;
                    end
                end else begin
                    w_bc_nxt = r_bc + 1'b1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (r_bc == L_BC_LAST) begin
                    w_bc_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_bc_nxt = r_bc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
